// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl
//   Coefficient bank controller for the 17-tap complex FIR. Host writes land in
//   the shadow bank; a commit swaps shadow and active banks on a sample boundary,
//   clears the FIR shift register, then holds o_out_valid low until the FIR
//   delay line has been refilled with samples processed under the new bank.
//   Also generates the FIR sample-rate strobe from the system clock.
//
// Ports
//   i_clock      system clock
//   i_reset      asynchronous active-low reset
//   i_enable     run enable for the divider and strobes
//   i_wr_en      coefficient write strobe
//   i_wr_addr    tap index of the write
//   i_wr_data    coefficient value of the write
//   i_commit     request shadow -> active swap
//   o_coeffs     active bank, tap k at [k*NB_COEFF +: NB_COEFF]
//   o_fir_valid  sample strobe to the FIR
//   o_fir_reset  synchronous clear to the FIR shift register
//   o_out_valid  FIR output derives entirely from the current bank
//   o_busy       a swap is pending or in progress
//   o_bank_sel   index of the active bank
//   o_cmd_err    one-cycle pulse on a rejected write or commit
module fir_coeff_ctrl #(
    parameter int unsigned NB_COEFF     = 16,
    parameter int unsigned N_COEFFS     = 17,
    parameter int unsigned OVERSAMPLING = 4,
    localparam int unsigned NB_ADDR     = $clog2(N_COEFFS),
    localparam int unsigned NB_OS_CNT   = $clog2(OVERSAMPLING)
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_wr_en,
    input  logic [NB_ADDR-1:0]           i_wr_addr,
    input  logic [NB_COEFF-1:0]          i_wr_data,
    input  logic                         i_commit,
    output logic [N_COEFFS*NB_COEFF-1:0] o_coeffs,
    output logic                         o_fir_valid,
    output logic                         o_fir_reset,
    output logic                         o_out_valid,
    output logic                         o_busy,
    output logic                         o_bank_sel,
    output logic                         o_cmd_err
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] SWAP  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]                         state;
    logic [NB_OS_CNT-1:0]               cnt;
    logic [NB_ADDR-1:0]                 flush_cnt;
    logic [N_COEFFS-1:0][NB_COEFF-1:0]  bank0;
    logic [N_COEFFS-1:0][NB_COEFF-1:0]  bank1;
    logic [N_COEFFS-1:0][NB_COEFF-1:0]  coeffs;
    logic                               bank_sel;

    logic addr_ok;
    logic wr_accept;
    logic cmd_err_next;
    logic cnt_wrap;

    always_comb begin
        // Extra bit keeps the bound correct even when N_COEFFS is a power of two.
        addr_ok      = {1'b0, i_wr_addr} < (NB_ADDR + 1)'(N_COEFFS);
        wr_accept    = i_wr_en && addr_ok && (state == RUN);
        cmd_err_next = (i_wr_en && !wr_accept) || (i_commit && (state != RUN));
        cnt_wrap     = (cnt == NB_OS_CNT'(OVERSAMPLING - 1));
    end

    // Sample-rate divider
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt         <= '0;
            o_fir_valid <= 1'b0;
        end else if (i_enable) begin
            cnt         <= cnt_wrap ? '0 : cnt + 1'b1;
            o_fir_valid <= cnt_wrap;
        end else begin
            o_fir_valid <= 1'b0;
        end
    end

    // Host writes only ever target the shadow bank
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            bank0 <= '0;
            bank1 <= '0;
        end else if (wr_accept) begin
            if (bank_sel) begin
                bank0[i_wr_addr] <= i_wr_data;
            end else begin
                bank1[i_wr_addr] <= i_wr_data;
            end
        end
    end

    // Swap sequencing
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= RUN;
            bank_sel    <= 1'b0;
            flush_cnt   <= '0;
            coeffs      <= '0;
            o_fir_reset <= 1'b0;
            o_out_valid <= 1'b0;
            o_cmd_err   <= 1'b0;
        end else begin
            o_cmd_err <= cmd_err_next;
            case (state)
                RUN: begin
                    if (i_commit) begin
                        state       <= PEND;
                        o_out_valid <= 1'b0;
                    end
                end
                PEND: begin
                    // Swap at the edge where the FIR consumes a sample, so the
                    // clear cycle that follows can never overlap a strobe.
                    if (o_fir_valid) begin
                        state       <= SWAP;
                        bank_sel    <= ~bank_sel;
                        coeffs      <= bank_sel ? bank0 : bank1;
                        o_fir_reset <= 1'b1;
                    end
                end
                SWAP: begin
                    state       <= FLUSH;
                    o_fir_reset <= 1'b0;
                    flush_cnt   <= '0;
                end
                FLUSH: begin
                    // Delay line holds N_COEFFS-1 past samples; refill them all.
                    if (o_fir_valid) begin
                        if (flush_cnt == NB_ADDR'(N_COEFFS - 2)) begin
                            state       <= RUN;
                            o_out_valid <= 1'b1;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign o_coeffs   = coeffs;
    assign o_busy     = (state != RUN);
    assign o_bank_sel = bank_sel;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
module tb_fir_coeff_ctrl;

    localparam int NB_COEFF = 16;
    localparam int N_COEFFS = 17;
    localparam int NB_ADDR  = 5;
    localparam int W        = NB_COEFF * N_COEFFS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b1;
    logic                wr_en = 1'b0;
    logic [NB_ADDR-1:0]  wr_addr = '0;
    logic [NB_COEFF-1:0] wr_data = '0;
    logic                commit = 1'b0;
    logic [W-1:0]        coeffs;
    logic                fir_valid, fir_reset, out_valid, busy, bank_sel, cmd_err;

    fir_coeff_ctrl dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_enable    (enable),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_commit    (commit),
        .o_coeffs    (coeffs),
        .o_fir_valid (fir_valid),
        .o_fir_reset (fir_reset),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_bank_sel  (bank_sel),
        .o_cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge following reset release.
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL unexpected_%s @cyc %0d: got event expected none", name, cyc);
    endtask

    task automatic at_cyc(input int n);
        if (n <= cyc) begin
            n_checks++;
            $display("FAIL at_cyc: got cycle %0d expected below %0d", cyc, n);
        end
        repeat (n - cyc) @(negedge clk);
    endtask

    function automatic logic [W-1:0] fill(input logic [NB_COEFF-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < N_COEFFS; k++) r[k*NB_COEFF +: NB_COEFF] = v;
        return r;
    endfunction

    // Scoreboard: expected event cycles, per event kind
    int q_rst[$];
    int q_err[$];
    int q_outv[$];
    logic out_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fir_reset) begin
                check("valid_during_clear", {{(W-1){1'b0}}, fir_valid}, '0);
                if (q_rst.size() == 0) unexpected("fir_reset");
                else check("fir_reset_cycle", cyc, q_rst.pop_front());
            end
            if (cmd_err) begin
                if (q_err.size() == 0) unexpected("cmd_err");
                else check("cmd_err_cycle", cyc, q_err.pop_front());
            end
            if (out_valid && !out_prev) begin
                if (q_outv.size() == 0) unexpected("out_valid_rise");
                else check("out_valid_rise_cycle", cyc, q_outv.pop_front());
            end
        end
        out_prev = out_valid;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fir_valid"}, {{(W-1){1'b0}}, fir_valid}, '0);
        check({tag, "_fir_reset"}, {{(W-1){1'b0}}, fir_reset}, '0);
        check({tag, "_out_valid"}, {{(W-1){1'b0}}, out_valid}, '0);
        check({tag, "_cmd_err"},   {{(W-1){1'b0}}, cmd_err},   '0);
        check({tag, "_busy"},      {{(W-1){1'b0}}, busy},      '0);
        check({tag, "_bank_sel"},  {{(W-1){1'b0}}, bank_sel},  '0);
        check({tag, "_coeffs"},    coeffs, '0);
    endtask

    logic [W-1:0] exp_v;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Strobe cadence from reset release
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            check("strobe_cadence", {{(W-1){1'b0}}, fir_valid}, {{(W-1){1'b0}}, (i % 4 == 0)});
            check("out_valid_idle", {{(W-1){1'b0}}, out_valid}, '0);
        end

        // Fill shadow bank, then an out-of-range write
        at_cyc(14);
        for (int k = 0; k < N_COEFFS; k++) begin
            wr_en = 1'b1; wr_addr = NB_ADDR'(k); wr_data = 16'h4000;
            at_cyc(cyc + 1);
        end
        wr_addr = 5'd17; wr_data = 16'h1234;
        q_err.push_back(32);
        at_cyc(32);
        wr_en = 1'b0;

        // Commit while cnt == 1; swap at the strobe edge 37, refill done at 121
        // (includes a 20-cycle enable stall in the flush)
        at_cyc(33);
        check("pre_swap_coeffs", coeffs, '0);
        check("pre_swap_bank_sel", {{(W-1){1'b0}}, bank_sel}, '0);
        commit = 1'b1;
        q_rst.push_back(37);
        q_outv.push_back(121);
        at_cyc(34);
        commit = 1'b0;
        at_cyc(35);
        check("pend_busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
        check("pend_coeffs_hold", coeffs, '0);
        at_cyc(37);
        check("swap_bank_sel", {{(W-1){1'b0}}, bank_sel}, {{(W-1){1'b0}}, 1'b1});
        check("swap_coeffs", coeffs, fill(16'h4000));

        // Rejected write and commit during flush
        at_cyc(50);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h1111;
        q_err.push_back(51);
        at_cyc(51);
        wr_en = 1'b0;
        at_cyc(60);
        commit = 1'b1;
        q_err.push_back(61);
        at_cyc(61);
        commit = 1'b0;

        // Enable stall mid-flush
        at_cyc(70);
        enable = 1'b0;
        for (int n = 71; n <= 90; n++) begin
            at_cyc(n);
            check("stall_no_strobe", {{(W-1){1'b0}}, fir_valid}, '0);
            check("stall_busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
        end
        enable = 1'b1;
        at_cyc(101);
        check("stall_extends_flush", {{(W-1){1'b0}}, out_valid}, '0);
        at_cyc(121);
        check("flush_done_busy", {{(W-1){1'b0}}, busy}, '0);
        check("flush_done_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});

        // Commit together with a write of tap 3
        at_cyc(125);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h7FFF; commit = 1'b1;
        q_rst.push_back(129);
        at_cyc(126);
        wr_en = 1'b0; commit = 1'b0;
        check("commit_clears_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        at_cyc(128);
        check("coeffs_hold_until_swap", coeffs, fill(16'h4000));
        at_cyc(129);
        exp_v = '0;
        exp_v[3*NB_COEFF +: NB_COEFF] = 16'h7FFF;
        check("swap2_coeffs", coeffs, exp_v);
        check("swap2_bank_sel", {{(W-1){1'b0}}, bank_sel}, '0);

        // Asynchronous reset mid-flush
        at_cyc(150);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Shadow bank must also have been cleared
        at_cyc(1);
        commit = 1'b1;
        q_rst.push_back(5);
        q_outv.push_back(69);
        at_cyc(2);
        commit = 1'b0;
        at_cyc(5);
        check("post_reset_shadow", coeffs, '0);
        check("post_reset_bank_sel", {{(W-1){1'b0}}, bank_sel}, {{(W-1){1'b0}}, 1'b1});
        at_cyc(75);

        while (q_rst.size() != 0) begin
            n_checks++;
            $display("FAIL missing_fir_reset: got none expected cycle %0d", q_rst.pop_front());
        end
        while (q_err.size() != 0) begin
            n_checks++;
            $display("FAIL missing_cmd_err: got none expected cycle %0d", q_err.pop_front());
        end
        while (q_outv.size() != 0) begin
            n_checks++;
            $display("FAIL missing_out_valid: got none expected cycle %0d", q_outv.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
Control block for the 17-tap complex FIR. It holds two coefficient banks (active and shadow) and takes host writes into the shadow bank. On commit it swaps banks at a safe sample boundary. It also generates the FIR sample-rate enable strobe and the FIR synchronous clear, and flags when FIR output is trustworthy again after a swap. It sits between the host register interface and the FIR's coefficient, valid and reset inputs.

Parameters:
NB_COEFF, 16, coefficient width, S(16,15)
N_COEFFS, 17, number of taps; also the number of entries per bank
OVERSAMPLING, 4, clock cycles per FIR sample; must be >= 2
NB_ADDR, $clog2(N_COEFFS) = 5, local; coefficient address width
NB_OS_CNT, $clog2(OVERSAMPLING) = 2, local; divider counter width

Ports:
i_clock  in  1  system clock; single clock domain
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  run enable; divider counter and strobes advance only when high
i_wr_en  in  1  coefficient write strobe, one cycle per write
i_wr_addr  in  NB_ADDR  tap index, 0..N_COEFFS-1
i_wr_data  in  NB_COEFF  coefficient value
i_commit  in  1  request swap of shadow bank to active
o_coeffs  out  N_COEFFS*NB_COEFF  active bank, flattened; tap k is at [k*NB_COEFF +: NB_COEFF]
o_fir_valid  out  1  registered sample strobe to the FIR
o_fir_reset  out  1  registered, active-high synchronous clear to the FIR shift register
o_out_valid  out  1  FIR output is computed entirely from the current bank
o_busy  out  1  state != RUN
o_bank_sel  out  1  index of the active bank
o_cmd_err  out  1  one-cycle pulse when a write or commit is rejected

Behaviour:
- Reset (i_reset=0, asynchronous):
  - Both banks cleared to 0; bank_sel=0; divider cnt=0; state=RUN.
  - Outputs: o_fir_valid=0, o_fir_reset=0, o_out_valid=0, o_cmd_err=0, o_coeffs all 0, o_busy=0.
  - Assertion of reset in any state aborts everything immediately.
- Divider:
  - On an edge with i_enable=1: cnt <= (cnt==OVERSAMPLING-1) ? 0 : cnt+1, and o_fir_valid <= (cnt==OVERSAMPLING-1).
  - On an edge with i_enable=0: cnt holds, o_fir_valid <= 0.
  - With i_enable held high from reset release, o_fir_valid is high in the cycles after edges OS, 2·OS, ..., each time for exactly one cycle.
- Writes:
  - Accepted only in RUN with i_wr_addr < N_COEFFS; written at that edge into bank !bank_sel.
  - Otherwise the write is dropped, o_cmd_err=1 for the next cycle, and neither bank changes.
  - The active bank is never written.
- FSM states: RUN, PEND, SWAP, FLUSH.
  - RUN: i_commit=1 -> PEND. A write in the same cycle as the commit is applied first.
  - PEND: on the first edge where o_fir_valid=1 (the FIR consumes a sample at that edge) -> SWAP. At that same edge bank_sel toggles and o_fir_reset <= 1.
  - SWAP: lasts one cycle, with o_fir_reset=1. Because OVERSAMPLING >= 2, no strobe coincides with it. Next state is FLUSH and o_fir_reset <= 0.
  - FLUSH: counts o_fir_valid strobes. On the edge where the (N_COEFFS-1)th strobe is high -> RUN and o_out_valid <= 1.
- o_out_valid: cleared on the edge entering PEND; stays 0 through PEND, SWAP and FLUSH.
- i_commit in PEND, SWAP or FLUSH: ignored, with an o_cmd_err pulse.
- i_enable=0 in PEND or FLUSH: FSM waits, since no strobes occur. The state and flush count hold.
- o_coeffs is a registered mux of the banks by bank_sel. It changes only on the edge entering SWAP.
- The FIR must give its clear priority over valid. This block guarantees the two are never high together.

Test Plan:
1. Reset release with i_enable=1 -> o_fir_valid high in cycles 4, 8, 12 only; o_out_valid=0; o_coeffs=0; o_bank_sel=0.
2. Write taps 0..16 = 0x4000 each, then commit on a cycle where cnt=1 -> PEND. Check:
   - SWAP is entered at the next strobe edge.
   - o_fir_reset is a single-cycle pulse.
   - o_bank_sel=1 and o_coeffs all 0x4000.
   - o_out_valid rises exactly 16 strobes (64 cycles) after SWAP.
3. Write addr=17 in RUN -> o_cmd_err pulse; both banks unchanged. Write during FLUSH -> o_cmd_err pulse; shadow bank unchanged.
4. Commit together with a write of tap 3 = 0x7FFF -> after the swap, o_coeffs tap 3 = 0x7FFF.
5. Hold i_enable=0 for 20 cycles while in FLUSH -> no strobes, state and count hold. After re-enable, the flush completes after the remaining strobes.
6. Assert i_reset low mid-FLUSH -> all outputs return to their reset values immediately (asynchronously) and both banks read 0.
